// File: rtl/div_meter_pkg.sv
// Shared types and defaults for the divided-clock edge meter.
package div_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/div_edge_meter_bit_sync.sv
// Reset-to-0 flop chain bringing one asynchronous bit into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/div_edge_meter.sv
// Edge detector, period meter and stall monitor for the divided clock div_in.
// Optional high-time measurement (tick_fall, meas_high) under DIV_EDGE_METER_FALL_EN.
module div_edge_meter
  import div_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             tick,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_sat,
  output logic             stalled,
  output logic             overrun,
`ifdef DIV_EDGE_METER_FALL_EN
  output logic             tick_fall,
  output logic [CNT_W-1:0] meas_high,
`endif
  output logic [1:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  state_t           state, state_nxt;
  logic             sync_out, sync_q;
  logic [CNT_W-1:0] cnt;
  logic             publish, load;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (div_in),
    .q   (sync_out)
  );

  // cnt equals the distance to the previous tick, so it is the period at the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      tick   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= sync_out;
      tick   <= sync_out & ~sync_q;
      if (tick)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    case (state)
      IDLE:    if (tick) state_nxt = MEASURE;
      MEASURE: begin
        if (tick) publish = 1'b1;
        else if (TIMEOUT_EN && cnt == TIMEOUT_C) state_nxt = STALL;
      end
      STALL:   if (tick) state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stalled   = (state == STALL);
  assign state_dbg = state;

  // Handshake: a transfer happens on any cycle with meas_valid & meas_ready. Held data is
  // frozen while valid & !ready; a publish then is dropped and flagged in sticky overrun.
  assign load = publish && (!meas_valid || meas_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_sat    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (load) begin
        meas_valid  <= 1'b1;
        meas_period <= cnt;
        meas_sat    <= (cnt == CNT_MAX);
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      if (publish && meas_valid && !meas_ready) overrun <= 1'b1;
    end
  end

`ifdef DIV_EDGE_METER_FALL_EN
  logic [CNT_W-1:0] hcnt, high_hold;

  // High time is latched at the falling tick and rides along with the next period publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_fall <= 1'b0;
      hcnt      <= '0;
      high_hold <= '0;
      meas_high <= '0;
    end else begin
      tick_fall <= ~sync_out & sync_q;
      if (tick)                 hcnt <= CNT_W'(1);
      else if (hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
      if (tick_fall) high_hold <= hcnt;
      if (load)      meas_high <= high_hold;
    end
  end
`endif

endmodule
